// File: rtl/core_if_fetch_buf_if.sv
// Bundle of the IF stage ports: imem request/response, flush redirect and the ID delivery port.
// Latency: none, wiring only.
// Backpressure: imem request via i_req_ready and ID delivery via i_ready; imem responses carry none.
interface core_if_fetch_buf_if #(
    parameter int PC_W   = 32,
    parameter int INST_W = 32
);
    logic              o_req_valid;
    logic              i_req_ready;
    logic [PC_W-1:0]   o_req_addr;
    logic              i_rsp_valid;
    logic [INST_W-1:0] i_rsp_inst;
    logic              i_rsp_err;
    logic              i_pipe_flush_req;
    logic [PC_W-1:0]   i_flush_pc;
    logic              o_valid;
    logic              i_ready;
    logic [INST_W-1:0] o_inst;
    logic [PC_W-1:0]   o_pc;
    logic              o_err;

    // Fetch stage side: drives requests and the ID port.
    modport master (
        output o_req_valid, o_req_addr, o_valid, o_inst, o_pc, o_err,
        input  i_req_ready, i_rsp_valid, i_rsp_inst, i_rsp_err,
        input  i_pipe_flush_req, i_flush_pc, i_ready
    );

    // Environment side: imem, EXU redirect and ID.
    modport slave (
        input  o_req_valid, o_req_addr, o_valid, o_inst, o_pc, o_err,
        output i_req_ready, i_rsp_valid, i_rsp_inst, i_rsp_err,
        output i_pipe_flush_req, i_flush_pc, i_ready
    );
endinterface

// File: rtl/core_if_fetch_buf.sv
// IF stage: sequential PC generator, credit-limited imem requests, in-order response buffer to ID.
// Latency: imem response to o_valid is 1 cycle (no bypass); first request 1 cycle after reset release.
// Backpressure: requests stall on credits/i_req_ready; buffer holds on i_ready=0; responses never stall.
module core_if_fetch_buf #(
    parameter int              PC_W     = 32,
    parameter int              INST_W   = 32,
    parameter int              DEPTH    = 4,
    parameter int              MAX_OS   = 2,
    parameter logic [PC_W-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    core_if_fetch_buf_if.master  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = $clog2(MAX_OS + 1);
    localparam logic [31:0] MAX_OS_W = 32'(MAX_OS);
    localparam logic [31:0] DEPTH_W  = 32'(DEPTH);

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic              err;
        logic [PC_W-1:0]   pc;
    } entry_t;

    entry_t          ent_mem [DEPTH];
    logic [PC_W-1:0] fetch_pc;
    logic [PC_W-1:0] rsp_pc;
    logic [OW-1:0]   os_cnt;
    logic [OW-1:0]   drop_cnt;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   cnt;
    logic            started;

    logic            flush;
    logic            room;
    logic            req_vld;
    logic            accept;
    logic            rsp;
    logic            drop;
    logic            push;
    logic            out_vld;
    logic            pop;
    logic [31:0]     os_w;
    logic [31:0]     cnt_w;

    // Credit check: every issued request already owns a buffer slot, so responses can never overflow.
    always_comb begin
        flush   = bus.i_pipe_flush_req;
        os_w    = 32'(os_cnt);
        cnt_w   = 32'(cnt);
        room    = (os_w < MAX_OS_W) && ((os_w + cnt_w) < DEPTH_W);
        // started keeps the request port quiet for the first cycle after reset
        req_vld = rst_n & started & ~flush & room;
        accept  = req_vld & bus.i_req_ready;
        rsp     = rst_n & bus.i_rsp_valid;
        // A response in a flush cycle is stale by definition; otherwise the drop counter decides.
        drop    = rsp & (flush | (drop_cnt != '0));
        push    = rsp & ~drop;
        out_vld = rst_n & (cnt != '0) & ~flush;
        pop     = out_vld & bus.i_ready;
    end

    assign bus.o_req_valid = req_vld;
    assign bus.o_req_addr  = fetch_pc;
    assign bus.o_valid     = out_vld;
    assign bus.o_inst      = ent_mem[rd_ptr].inst;
    assign bus.o_pc        = ent_mem[rd_ptr].pc;
    assign bus.o_err       = ent_mem[rd_ptr].err;

    // Control state: PCs, outstanding/drop counters, buffer pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            os_cnt   <= '0;
            drop_cnt <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            cnt      <= '0;
            started  <= 1'b0;
        end else begin
            started <= 1'b1;
            // Outstanding count follows the imem protocol even across flushes.
            case ({accept, rsp})
                2'b10:   os_cnt <= os_cnt + 1'b1;
                2'b01:   os_cnt <= os_cnt - 1'b1;
                default: os_cnt <= os_cnt;
            endcase
            if (flush) begin
                fetch_pc <= bus.i_flush_pc;
                rsp_pc   <= bus.i_flush_pc;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                cnt      <= '0;
                // Everything still in flight after this cycle belongs to the old path.
                drop_cnt <= os_cnt - OW'(rsp);
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + PC_W'(4);
                end
                if (rsp && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - 1'b1;
                end
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    rsp_pc <= rsp_pc + PC_W'(4);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push, pop})
                    2'b10:   cnt <= cnt + 1'b1;
                    2'b01:   cnt <= cnt - 1'b1;
                    default: cnt <= cnt;
                endcase
            end
        end
    end

    // Buffer storage: payload only, no reset needed since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_mem[wr_ptr] <= '{inst: bus.i_rsp_inst, err: bus.i_rsp_err, pc: rsp_pc};
        end
    end

    // The credit rule must make a push into a full buffer impossible.
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (cnt == CW'(DEPTH))));

    // imem must never answer more requests than were issued.
    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.i_rsp_valid && (os_cnt == '0)));

endmodule

// File: tb/tb_core_if_fetch_buf.sv
// Bench for core_if_fetch_buf: imem model, directed stimulus with scoreboard, decoupled monitor.
// Latency: imem latency per test (fixed or random 1..4), deliveries checked as they happen.
// Backpressure: i_req_ready gated by a grant budget, i_ready driven per test.
module tb_core_if_fetch_buf;
    logic clk;
    logic rst_n;
    int   cyc = 0;

    core_if_fetch_buf_if #(.PC_W(32), .INST_W(32)) bus ();

    core_if_fetch_buf dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic        err;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    exp_t        exp_q [$];
    pend_t       pend [$];
    logic [31:0] acc_log [$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          grant_left = 0;
    int          imem_lat = 1;
    bit          rnd_rdy = 0;
    bit          rnd_lat = 0;
    logic [31:0] err_addr = 32'h0000_0001;
    int          acc_cnt = 0;
    int          first_acc_cyc = -1;
    int          first_vld_cyc = -1;
    pend_t       p;
    int          lat;
    exp_t        e;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // imem model: in-order responses, one per cycle, no earlier than the latency after accept.
    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            pend.delete();
            bus.i_rsp_valid = 1'b0;
            bus.i_rsp_inst  = '0;
            bus.i_rsp_err   = 1'b0;
            bus.i_req_ready = 1'b0;
        end else begin
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                p = pend.pop_front();
                bus.i_rsp_valid = 1'b1;
                bus.i_rsp_inst  = inst_of(p.addr);
                bus.i_rsp_err   = (p.addr == err_addr);
            end else begin
                bus.i_rsp_valid = 1'b0;
                bus.i_rsp_inst  = '0;
                bus.i_rsp_err   = 1'b0;
            end
            bus.i_req_ready = (grant_left > 0) && (rnd_rdy ? ($urandom_range(0, 1) == 1) : 1'b1);
        end
        #2;
        if (rst_n && bus.o_req_valid && bus.i_req_ready) begin
            lat = rnd_lat ? int'($urandom_range(1, 4)) : imem_lat;
            pend.push_back('{addr: bus.o_req_addr, due: cyc + lat});
            acc_log.push_back(bus.o_req_addr);
            acc_cnt++;
            grant_left--;
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
        end
    end

    // Monitor: every delivery to ID is matched against the head of the scoreboard.
    always @(negedge clk) begin
        #4;
        if (rst_n && bus.o_valid && bus.i_ready) begin
            if (first_vld_cyc < 0) first_vld_cyc = cyc;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_delivery: got pc %h expected no delivery", bus.o_pc);
            end else begin
                e = exp_q.pop_front();
                chk("o_pc", bus.o_pc, e.pc);
                chk("o_inst", bus.o_inst, inst_of(e.pc));
                chk("o_err", 32'(bus.o_err), 32'(e.err));
            end
        end
    end

    task automatic expect_run(input logic [31:0] base, input int n, input logic [31:0] eaddr);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back('{pc: base + 32'(4 * k), err: ((base + 32'(4 * k)) == eaddr)});
        end
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_drain_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_acc(input string name, input int target, input int budget);
        int n = 0;
        while (acc_cnt < target && n < budget) begin
            @(negedge clk);
            #4;
            n++;
        end
        chk({name, "_accepts"}, 32'(acc_cnt), 32'(target));
    endtask

    initial begin
        int acc0;
        bit seen;
        rst_n = 1'b0;
        bus.i_ready          = 1'b1;
        bus.i_pipe_flush_req = 1'b0;
        bus.i_flush_pc       = '0;

        // 1: reset, then three fetches at latency 1
        repeat (3) @(negedge clk);
        #1;
        chk("t1_rst_req_valid", 32'(bus.o_req_valid), 32'd0);
        chk("t1_rst_valid", 32'(bus.o_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t1_post_rst_req_valid", 32'(bus.o_req_valid), 32'd0);
        chk("t1_post_rst_valid", 32'(bus.o_valid), 32'd0);
        imem_lat = 1;
        expect_run(32'h8000_0000, 3, err_addr);
        grant_left = 3;
        drain("t1", 60);
        chk("t1_addr0", acc_log[0], 32'h8000_0000);
        chk("t1_addr1", acc_log[1], 32'h8000_0004);
        chk("t1_addr2", acc_log[2], 32'h8000_0008);
        chk("t1_rsp_to_id_latency", 32'(first_vld_cyc - first_acc_cyc), 32'd2);

        // 2: ID stalled, credits stop issue after DEPTH requests
        @(negedge clk);
        bus.i_ready = 1'b0;
        acc0 = acc_cnt;
        grant_left = 10;
        repeat (20) @(negedge clk);
        #1;
        chk("t2_accepts_while_stalled", 32'(acc_cnt - acc0), 32'd4);
        chk("t2_req_valid_full", 32'(bus.o_req_valid), 32'd0);
        chk("t2_valid_full", 32'(bus.o_valid), 32'd1);
        @(negedge clk);
        grant_left = 0;
        expect_run(32'h8000_000C, 4, err_addr);
        bus.i_ready = 1'b1;
        drain("t2", 60);

        // 3: flush with two requests outstanding
        @(negedge clk);
        imem_lat = 5;
        acc0 = acc_cnt;
        grant_left = 2;
        wait_acc("t3_pre", acc0 + 2, 40);
        @(negedge clk);
        bus.i_pipe_flush_req = 1'b1;
        bus.i_flush_pc       = 32'h0000_1000;
        #1;
        chk("t3_req_valid_in_flush", 32'(bus.o_req_valid), 32'd0);
        @(negedge clk);
        bus.i_pipe_flush_req = 1'b0;
        expect_run(32'h0000_1000, 2, err_addr);
        acc0 = acc_cnt;
        grant_left = 2;
        drain("t3", 100);
        chk("t3_first_addr_after_flush", acc_log[acc0], 32'h0000_1000);

        // 4: flush in the very cycle a response arrives, two outstanding
        @(negedge clk);
        imem_lat = 3;
        acc0 = acc_cnt;
        grant_left = 2;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            #2;
            seen = bus.i_rsp_valid;
        end
        chk("t4_rsp_seen", 32'(seen), 32'd1);
        chk("t4_outstanding_at_flush", 32'(acc_cnt - acc0), 32'd2);
        bus.i_pipe_flush_req = 1'b1;
        bus.i_flush_pc       = 32'h0000_2000;
        @(negedge clk);
        bus.i_pipe_flush_req = 1'b0;
        expect_run(32'h0000_2000, 2, err_addr);
        grant_left = 2;
        drain("t4", 100);

        // 5: random handshakes and latency, one faulting fetch
        @(negedge clk);
        err_addr = 32'h0000_2018;
        rnd_rdy = 1'b1;
        rnd_lat = 1'b1;
        expect_run(32'h0000_2008, 12, err_addr);
        grant_left = 12;
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) begin
            @(negedge clk);
            bus.i_ready = ($urandom_range(0, 1) == 1);
        end
        bus.i_ready = 1'b1;
        drain("t5", 40);
        rnd_rdy = 1'b0;
        rnd_lat = 1'b0;
        err_addr = 32'h0000_0001;

        // 6: reset in the middle of a full, stalled stream
        @(negedge clk);
        imem_lat = 1;
        bus.i_ready = 1'b0;
        grant_left = 10;
        repeat (15) @(negedge clk);
        #1;
        chk("t6_full_valid", 32'(bus.o_valid), 32'd1);
        chk("t6_full_head_pc", bus.o_pc, 32'h0000_2038);
        @(negedge clk);
        rst_n = 1'b0;
        grant_left = 0;
        @(negedge clk);
        #1;
        chk("t6_rst_valid", 32'(bus.o_valid), 32'd0);
        chk("t6_rst_req_valid", 32'(bus.o_req_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        #1;
        chk("t6_post_rst_valid", 32'(bus.o_valid), 32'd0);
        chk("t6_post_rst_req_valid", 32'(bus.o_req_valid), 32'd0);
        bus.i_ready = 1'b1;
        acc0 = acc_cnt;
        expect_run(32'h8000_0000, 3, err_addr);
        grant_left = 3;
        drain("t6", 60);
        chk("t6_restart_addr", acc_log[acc0], 32'h8000_0000);

        // Quiet tail: any stray delivery is caught by the monitor.
        repeat (20) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
